reg_stack: RTL and testbench
============================

Name: reg_stack

Overview:
- Register-file-based LIFO operand stack for the RegisterStack CPU datapath.
- Each clock it executes one stack action selected by a 4-bit action code: idle, push, pop, dup or swap.
- The two topmost entries are continuously visible as `top` and `next`. These feed the ALU and operand paths.
- Implemented as a shift-register array: entry 0 is the top and entry DEPTH-1 is the bottom.

Parameters:
- DATA_WIDTH, 16, width of each stack entry and of `in_val`/`top`/`next`.
- DEPTH, 8, number of entries (must be ≥ 2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_val  input  DATA_WIDTH  value written to the top on a push.
- stackAction  input  4  action code, sampled on the rising edge.
- top  output  DATA_WIDTH  entry 0 (top of stack).
- next  output  DATA_WIDTH  entry 1 (second from top).

Behaviour:
- Storage is an array s[0..DEPTH-1] of DATA_WIDTH registers. `top` = s[0] and `next` = s[1], both driven combinationally from the registers.
- Reset (rst=1, asynchronous): every s[i] = 0, so top = 0 and next = 0. Reset overrides any action in progress. Normal operation resumes on the first rising edge after rst deasserts.
- Empty slots always hold 0. Reading an empty position returns 0.
- Action codes, one action per cycle, result visible right after the edge (latency 1 edge):
  - 4'b0000 idle: no change.
  - 4'b1000 push: s[0] <= in_val; s[i] <= s[i-1] for i ≥ 1.
  - 4'b0001 pop: s[i] <= s[i+1] for i < DEPTH-1; s[DEPTH-1] <= 0. The popped value is discarded.
  - 4'b0010 pop: identical to 4'b0001. It is a second encoding reserved for the pop-to-datapath instruction.
  - 4'b0101 dup: s[0] <= s[0]; s[i] <= s[i-1] for i ≥ 1.
  - 4'b0111 swap: s[0] <= s[1]; s[1] <= s[0]; deeper entries unchanged.
  - All other codes: treated as idle, no change.
- Push or dup when full: the bottom entry s[DEPTH-1] is silently discarded. There is no error flag.
- Pop on an empty stack: the stack stays all-zero.
- Swap with fewer than 2 valid entries: the zero fill is swapped like data. Example: one entry A gives top=0, next=A.
- Holding an action for N cycles executes it N times. The driving sequencer must return to idle between single actions.

Decomposition:
- Shared package (`stack_pkg`):
  - Action-code constants: ACT_IDLE=4'b0000, ACT_PUSH=4'b1000, ACT_POP=4'b0001, ACT_POP2=4'b0010, ACT_DUP=4'b0101, ACT_SWAP=4'b0111.
  - Default DATA_WIDTH and DEPTH values.
- One sub-module is natural: `stack_cell`, a single-entry register with asynchronous clear and a next-value mux selecting hold, left neighbour, right neighbour, in_val or zero. The top-level instantiates DEPTH cells and decodes the action into per-cell selects; cells 0 and 1 carry the swap cross-connect.

Test Plan:
- Reset: assert rst mid-operation with stack holding 3,1 → top=0 and next=0 immediately, without waiting for a clock edge.
- Push sequence: after reset, push 1, then idle → top=1, next=0. Push 3 → top=3, next=1.
- Pop then push: from 3,1, pop (0001) → top=1, next=0. Push 7 → top=7, next=1.
- Swap, dup, pops:
  - From 7,1, swap (0111) → top=1, next=7.
  - Dup (0101) → top=1, next=1.
  - Pop (0001) → top=1, next=7.
  - Pop (0010) → top=7, next=0.
- Boundaries:
  - Push DEPTH+1 distinct values → the first value is lost; DEPTH pops return the rest in LIFO order, then top=0.
  - A further pop on empty → top=0, next=0.
  - Swap with one entry A → top=0, next=A.
  - Undefined code 4'b1111 → no change.

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg: action codes, default sizes and per-cell select decode for reg_stack
package stack_pkg;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_DEPTH      = 8;
   localparam logic [3:0] ACT_IDLE = 4'b0000;
   localparam logic [3:0] ACT_PUSH = 4'b1000;
   localparam logic [3:0] ACT_POP  = 4'b0001;
   localparam logic [3:0] ACT_POP2 = 4'b0010;
   localparam logic [3:0] ACT_DUP  = 4'b0101;
   localparam logic [3:0] ACT_SWAP = 4'b0111;
   typedef enum logic [2:0] {SEL_HOLD, SEL_LEFT, SEL_RIGHT, SEL_IN, SEL_ZERO} sel_t;
   // left = toward the top (idx-1), right = toward the bottom (idx+1)
   function automatic sel_t cell_sel(input logic [3:0] act, input int idx, input int depth);
      return (act == ACT_PUSH) ? (idx == 0 ? SEL_IN : SEL_LEFT) :
             (act == ACT_POP || act == ACT_POP2) ? (idx == depth - 1 ? SEL_ZERO : SEL_RIGHT) :
             (act == ACT_DUP) ? (idx == 0 ? SEL_HOLD : SEL_LEFT) :
             (act == ACT_SWAP) ? (idx == 0 ? SEL_RIGHT : idx == 1 ? SEL_LEFT : SEL_HOLD) :
             SEL_HOLD;
   endfunction
endpackage

// File: rtl/stack_cell.sv
// stack_cell: one stack entry with async clear and a hold/left/right/in/zero next-value mux
module stack_cell
   import stack_pkg::*;
#(
   parameter int W = DEF_DATA_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  sel_t         sel,
   input  logic [W-1:0] left,
   input  logic [W-1:0] right,
   input  logic [W-1:0] in_val,
   output logic [W-1:0] q
);
   logic [W-1:0] val_q, val_d;
   always_comb begin
      val_d = (sel == SEL_LEFT)  ? left   :
              (sel == SEL_RIGHT) ? right  :
              (sel == SEL_IN)    ? in_val :
              (sel == SEL_ZERO)  ? '0     : val_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) val_q <= '0;
      else     val_q <= val_d;
   end
   assign q = val_q;
endmodule

// File: rtl/reg_stack.sv
// reg_stack: shift-register LIFO operand stack exposing the two topmost entries
module reg_stack
   import stack_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_val,
   input  logic [3:0]            stackAction,
   output logic [DATA_WIDTH-1:0] top,
   output logic [DATA_WIDTH-1:0] next
);
   // ext[i+1] is entry i; ext[0] and ext[DEPTH+1] are zero guards for the end cells
   logic [DATA_WIDTH-1:0] ext [DEPTH+2];
   sel_t                  sel [DEPTH];
   assign ext[0]       = '0;
   assign ext[DEPTH+1] = '0;
   for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      assign sel[i] = cell_sel(stackAction, i, DEPTH);
      stack_cell #(.W(DATA_WIDTH)) u_cell (
         .clk    (clk),
         .rst    (rst),
         .sel    (sel[i]),
         .left   (ext[i]),
         .right  (ext[i+2]),
         .in_val (in_val),
         .q      (ext[i+1])
      );
   end
   assign top  = ext[1];
   assign next = ext[2];
endmodule

// File: tb/tb_reg_stack.sv
// tb_reg_stack: scoreboard bench for reg_stack using directed literals and a reference model
module tb_reg_stack;
   import stack_pkg::*;
   localparam int W = DEF_DATA_WIDTH;
   localparam int D = DEF_DEPTH;

   typedef struct {
      string        tag;
      logic [W-1:0] t;
      logic [W-1:0] n;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] in_val = '0;
   logic [3:0]   stack_action = ACT_IDLE;
   logic [W-1:0] top, next;

   exp_t         sb [$];
   logic [W-1:0] m [D];
   logic [3:0]   codes [7];
   int           checks = 0;
   int           failures = 0;

   reg_stack #(.DATA_WIDTH(W), .DEPTH(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_val      (in_val),
      .stackAction (stack_action),
      .top         (top),
      .next        (next)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < D; i++) m[i] = '0;
   endtask

   task automatic model_apply(input logic [3:0] a, input logic [W-1:0] v);
      logic [W-1:0] t;
      if (a == ACT_PUSH || a == ACT_DUP) begin
         t = (a == ACT_PUSH) ? v : m[0];
         for (int i = D - 1; i > 0; i--) m[i] = m[i-1];
         m[0] = t;
      end else if (a == ACT_POP || a == ACT_POP2) begin
         for (int i = 0; i < D - 1; i++) m[i] = m[i+1];
         m[D-1] = '0;
      end else if (a == ACT_SWAP) begin
         t = m[0];
         m[0] = m[1];
         m[1] = t;
      end
   endtask

   task automatic drive_and_check(input logic [3:0] a, input logic [W-1:0] v);
      exp_t e;
      stack_action = a;
      in_val = v;
      @(posedge clk);
      #1;
      stack_action = ACT_IDLE;
      if (sb.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_top"}, 32'(top), 32'(e.t));
         chk({e.tag, "_next"}, 32'(next), 32'(e.n));
      end
   endtask

   task automatic step(input logic [3:0] a, input logic [W-1:0] v, input string tag,
                       input logic [W-1:0] et, input logic [W-1:0] en);
      model_apply(a, v);
      sb.push_back('{tag, et, en});
      drive_and_check(a, v);
   endtask

   task automatic step_rnd(input logic [3:0] a, input logic [W-1:0] v);
      model_apply(a, v);
      sb.push_back('{$sformatf("rnd_a%0h", a), m[0], m[1]});
      drive_and_check(a, v);
   endtask

   initial begin
      codes[0] = ACT_IDLE; codes[1] = ACT_PUSH; codes[2] = ACT_POP; codes[3] = ACT_POP2;
      codes[4] = ACT_DUP;  codes[5] = ACT_SWAP; codes[6] = 4'b1111;
      model_clear();
      #3;
      chk("reset_top", 32'(top), 32'd0);
      chk("reset_next", 32'(next), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      step(ACT_PUSH, 16'd1, "push1", 16'd1, 16'd0);
      step(ACT_IDLE, 16'd9, "idle", 16'd1, 16'd0);
      step(ACT_PUSH, 16'd3, "push3", 16'd3, 16'd1);
      step(ACT_POP,  16'd0, "pop", 16'd1, 16'd0);
      step(ACT_PUSH, 16'd7, "push7", 16'd7, 16'd1);
      step(ACT_SWAP, 16'd0, "swap", 16'd1, 16'd7);
      step(ACT_DUP,  16'd0, "dup", 16'd1, 16'd1);
      step(ACT_POP,  16'd0, "pop_a", 16'd1, 16'd7);
      step(ACT_POP2, 16'd0, "pop2", 16'd7, 16'd0);
      step(ACT_POP,  16'd0, "pop_last", 16'd0, 16'd0);

      for (int k = 1; k <= D + 1; k++)
         step(ACT_PUSH, W'(k), $sformatf("fill%0d", k), W'(k), W'(k - 1));
      for (int j = 1; j <= D; j++)
         step(ACT_POP, 16'd0, $sformatf("drain%0d", j),
              (j == D) ? 16'd0 : W'(D + 1 - j), (j >= D - 1) ? 16'd0 : W'(D - j));
      step(ACT_POP,  16'd0, "pop_empty", 16'd0, 16'd0);
      step(ACT_PUSH, 16'h00AA, "push_a", 16'h00AA, 16'd0);
      step(ACT_SWAP, 16'd0, "swap_one", 16'd0, 16'h00AA);
      step(4'b1111,  16'h5555, "undef", 16'd0, 16'h00AA);
      step(ACT_POP2, 16'd0, "pop2_zero", 16'h00AA, 16'd0);

      for (int r = 0; r < 300; r++)
         step_rnd(codes[$urandom_range(0, 6)], W'($urandom));

      step(ACT_PUSH, 16'd1, "pre_rst1", 16'd1, m[0]);
      step(ACT_PUSH, 16'd3, "pre_rst3", 16'd3, 16'd1);
      stack_action = ACT_PUSH;
      in_val = 16'hBEEF;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_top", 32'(top), 32'd0);
      chk("async_rst_next", 32'(next), 32'd0);
      stack_action = ACT_IDLE;
      @(negedge clk);
      chk("rst_hold_top", 32'(top), 32'd0);
      rst = 1'b0;
      model_clear();
      step(ACT_IDLE, 16'd0, "post_rst", 16'd0, 16'd0);
      step(ACT_PUSH, 16'h1234, "post_rst_push", 16'h1234, 16'd0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
